mem_stage_access: RTL and testbench

- Memory-stage consumer of the Execute/Memory pipeline register in the 4-stage core.
- Turns the latched load and store controls into a request/acknowledge transaction with data memory.
- Holds the upstream pipeline with a stall while the transaction is outstanding.
- Registers the stage result into the Memory/Writeback register fields.

---
 rtl/mem_stage_access.sv | 172 +++++++++++++++++
 tb/tb_mem_stage_access.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
// ============================================================================
// Module   : mem_stage_access
// Purpose  : Memory stage of the 4-stage core. Runs load/store req/ack
//            transactions, stalls upstream while busy, feeds the M/W register.
//            Optional define MEM_TIMEOUT_EN aborts stuck transactions.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_stage_access #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          validM,
    input  logic [31:0]   PCM,
    input  logic [3:0]    rdM,
    input  logic [DW-1:0] aluResultM,
    input  logic [DW-1:0] op2M,
    input  logic          isLdM,
    input  logic          isStM,
    input  logic          isWbM,
    input  logic          isCallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          stallM,
    output logic          validW,
    output logic          isWbW,
    output logic          isCallW,
    output logic [31:0]   PCW,
    output logic [3:0]    rdW,
    output logic [DW-1:0] resultW,
    output logic          mem_err
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic          r_req;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic          r_validW;
    logic          r_isWbW;
    logic          r_isCallW;
    logic [31:0]   r_PCW;
    logic [3:0]    r_rdW;
    logic [DW-1:0] r_resultW;

    logic w_memop;
    logic w_busy;
    logic w_timeout;

    assign w_memop = validM & (isLdM | isStM);
    assign w_busy  = (r_state == c_BUSY);

`ifdef MEM_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT + 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_err;

    // Fires on the TIMEOUT-th BUSY cycle without ack; a same-cycle ack wins.
    assign w_timeout = w_busy & ~mem_ack & (r_cnt == c_CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (!w_busy)
                r_cnt <= '0;
            else if (!mem_ack)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end

    assign mem_err = r_err;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign mem_err          = 1'b0;
    assign w_unused_timeout = (TIMEOUT == 0);
`endif

    // Gated by reset so upstream is released the moment reset hits.
    assign stallM = ~reset & (w_busy ? ~(mem_ack | w_timeout) : w_memop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_validW  <= 1'b0;
            r_isWbW   <= 1'b0;
            r_isCallW <= 1'b0;
            r_PCW     <= '0;
            r_rdW     <= '0;
            r_resultW <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_memop) begin
                        r_req     <= 1'b1;
                        r_we      <= isStM;
                        r_addr    <= aluResultM[AW-1:0];
                        r_wdata   <= op2M;
                        r_validW  <= 1'b0;
                        r_isWbW   <= 1'b0;
                        r_isCallW <= 1'b0;
                        r_state   <= c_BUSY;
                    end else begin
                        r_validW  <= validM;
                        r_PCW     <= PCM;
                        r_rdW     <= rdM;
                        r_resultW <= aluResultM;
                        r_isWbW   <= validM & isWbM;
                        r_isCallW <= validM & isCallM;
                    end
                end
                c_BUSY: begin
                    if (mem_ack) begin
                        // M inputs are held by the stall, so retire from them directly.
                        r_req     <= 1'b0;
                        r_state   <= c_IDLE;
                        r_validW  <= 1'b1;
                        r_PCW     <= PCM;
                        r_rdW     <= rdM;
                        r_isCallW <= isCallM;
                        r_resultW <= r_we ? aluResultM : mem_rdata;
                        r_isWbW   <= ~r_we & isWbM;
                    end else begin
                        if (w_timeout) begin
                            r_req   <= 1'b0;
                            r_state <= c_IDLE;
                        end
                        r_validW  <= 1'b0;
                        r_isWbW   <= 1'b0;
                        r_isCallW <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign mem_req   = r_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign validW    = r_validW;
    assign isWbW     = r_isWbW;
    assign isCallW   = r_isCallW;
    assign PCW       = r_PCW;
    assign rdW       = r_rdW;
    assign resultW   = r_resultW;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_access.sv
// ============================================================================
// Module   : tb_mem_stage_access
// Purpose  : Self-checking bench for mem_stage_access; directed cases plus
//            randomized instruction stream against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        validM;
    logic [31:0] PCM;
    logic [3:0]  rdM;
    logic [31:0] aluResultM;
    logic [31:0] op2M;
    logic        isLdM, isStM, isWbM, isCallM;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stallM;
    logic        validW, isWbW, isCallW;
    logic [31:0] PCW;
    logic [3:0]  rdW;
    logic [31:0] resultW;
    logic        mem_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_access #(.DW(32), .AW(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .validM(validM), .PCM(PCM), .rdM(rdM),
        .aluResultM(aluResultM), .op2M(op2M), .isLdM(isLdM), .isStM(isStM),
        .isWbM(isWbM), .isCallM(isCallM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .stallM(stallM), .validW(validW), .isWbW(isWbW),
        .isCallW(isCallW), .PCW(PCW), .rdW(rdW), .resultW(resultW),
        .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] rd,
                         input logic [31:0] alu, input logic [31:0] op2,
                         input logic ld, input logic st, input logic wb, input logic call);
        validM = v; PCM = pc; rdM = rd; aluResultM = alu; op2M = op2;
        isLdM = ld; isStM = st; isWbM = wb; isCallM = call;
    endtask

    // Transaction-level model: one instruction, d BUSY cycles before ack.
    task automatic run_instr(input logic v, input logic [31:0] pc, input logic [3:0] rd,
                             input logic [31:0] alu, input logic [31:0] op2,
                             input logic ld, input logic st, input logic wb, input logic call,
                             input int d, input logic [31:0] rdata, input logic stray_ack);
        logic memop;
        memop = v & (ld | st);
        drive(v, pc, rd, alu, op2, ld, st, wb, call);
        mem_ack   = memop ? 1'b0 : stray_ack;
        mem_rdata = rdata;
        #1;
        chk("stall_issue", stallM, memop);
        if (!memop) begin
            tick();
            mem_ack = 1'b0;
            chk("pt_validW", validW, v);
            chk("pt_PCW", PCW, pc);
            chk("pt_rdW", rdW, rd);
            chk("pt_resultW", resultW, alu);
            chk("pt_isWbW", isWbW, v & wb);
            chk("pt_isCallW", isCallW, v & call);
            chk("pt_mem_req", mem_req, 1'b0);
        end else begin
            tick();
            chk("req_mem_req", mem_req, 1'b1);
            chk("req_mem_we", mem_we, st);
            chk("req_mem_addr", mem_addr, alu);
            chk("req_mem_wdata", mem_wdata, op2);
            chk("req_validW", validW, 1'b0);
            for (int i = 0; i < d; i++) begin
                #1;
                chk("busy_stall", stallM, 1'b1);
                tick();
                chk("busy_mem_req", mem_req, 1'b1);
                chk("busy_mem_addr", mem_addr, alu);
                chk("busy_validW", validW, 1'b0);
                chk("busy_isWbW", isWbW, 1'b0);
            end
            mem_ack = 1'b1;
            #1;
            chk("ack_stall", stallM, 1'b0);
            tick();
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk("ret_mem_req", mem_req, 1'b0);
            chk("ret_validW", validW, 1'b1);
            chk("ret_PCW", PCW, pc);
            chk("ret_rdW", rdW, rd);
            chk("ret_resultW", resultW, st ? alu : rdata);
            chk("ret_isWbW", isWbW, st ? 1'b0 : wb);
            chk("ret_isCallW", isCallW, call);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_validW", validW, 1'b0);
        chk("rst_resultW", resultW, 32'h0);
        chk("rst_PCW", PCW, 32'h0);
        chk("rst_stallM", stallM, 1'b0);
        chk("rst_mem_err", mem_err, 1'b0);
        reset = 1'b0;

        // ALU pass-through
        run_instr(1'b1, 32'h40, 4'd3, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        // Load, ack after 3 waiting BUSY cycles
        run_instr(1'b1, 32'h44, 4'd5, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 32'hDEADBEEF, 1'b0);
        // Store acked on first BUSY cycle
        run_instr(1'b1, 32'h48, 4'd0, 32'h200, 32'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0, 1'b0);
        // Load immediately followed by store
        run_instr(1'b1, 32'h4C, 4'd7, 32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1, 32'h5555AAAA, 1'b0);
        run_instr(1'b1, 32'h50, 4'd8, 32'h304, 32'h77, 1'b0, 1'b1, 1'b1, 1'b0, 2, 32'h0, 1'b0);
        // Both ld and st set: treated as store
        run_instr(1'b1, 32'h54, 4'd9, 32'h306, 32'h99, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h1111, 1'b0);
        // Bubble carrying memory controls: no request, stray ack ignored
        run_instr(1'b0, 32'h58, 4'd1, 32'h400, 32'h1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 32'hFFFF, 1'b1);

        // Reset during BUSY
        drive(1'b1, 32'h60, 4'd2, 32'h500, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("pre_rst_busy_req", mem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_stallM", stallM, 1'b0);
        chk("mid_rst_validW", validW, 1'b0);
        chk("mid_rst_PCW", PCW, 32'h0);
        chk("mid_rst_resultW", resultW, 32'h0);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_mem_req", mem_req, 1'b0);
        chk("late_ack_validW", validW, 1'b0);
        chk("late_ack_resultW", resultW, 32'h0);
        chk("late_ack_stallM", stallM, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // No ack: aborts after 4 BUSY cycles
        drive(1'b1, 32'h70, 4'd4, 32'h600, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("to_stall", stallM, 1'b1);
            tick();
        end
        chk("to_last_stall", stallM, 1'b0);
        tick();
        chk("to_mem_req", mem_req, 1'b0);
        chk("to_mem_err", mem_err, 1'b1);
        chk("to_validW", validW, 1'b0);
        run_instr(1'b1, 32'h74, 4'd6, 32'hABCD, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 32'h0, 1'b0);
        chk("to_err_sticky", mem_err, 1'b1);
`else
        chk("no_to_mem_err", mem_err, 1'b0);
`endif

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            logic [2:0] kind;
            logic v, ld, st;
            kind = 3'($urandom_range(0, 4));
            v  = (kind != 3'd0);
            ld = (kind == 3'd2) || (kind == 3'd4) || (kind == 3'd0 && $urandom_range(0, 1) == 1);
            st = (kind == 3'd3) || (kind == 3'd4);
            run_instr(v, $urandom, 4'($urandom), $urandom, $urandom, ld, st,
                      1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom,
                      1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
